// File: rtl/adc_spi_seq_pkg.sv
// Shared types and constants for the ADC SPI sampling sequencer.
// Holds the state enums, AD7928 control-word field positions and sizes.
package adc_spi_seq_pkg;

    // Bit-level SPI states; GAP is the inter-frame chip-select high time.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_LO,
        SCK_HI,
        GAP
    } state_e;

    // Burst-level sequencer states.
    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_XFER,
        SQ_GAP
    } seq_e;

    localparam int FRAME_BITS  = 16;
    localparam int N_FRAMES    = 4;
    localparam int SAMPLE_W    = 12;

    // Control-word field positions
    localparam int WRITE_BIT   = 15;
    localparam int ADDR_LSB    = 10;
    localparam int PM_LSB      = 8;
    localparam int RANGE_BIT   = 5;
    localparam int CODING_BIT  = 4;

    // Returned-word field position
    localparam int RX_ADDR_LSB = 12;

    // WRITE, no sequencer, normal power, range 0..REFIN, straight binary.
    function automatic logic [FRAME_BITS-1:0] ctrl_word(input logic [2:0] addr);
        logic [FRAME_BITS-1:0] w;
        w                 = '0;
        w[WRITE_BIT]      = 1'b1;
        w[ADDR_LSB +: 3]  = addr;
        w[PM_LSB +: 2]    = 2'b11;
        w[RANGE_BIT]      = 1'b1;
        w[CODING_BIT]     = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/adc_spi_seq_frame.sv
// Shifts one 16-bit SPI frame: SETUP, then 16 x (SCK_LO, SCK_HI).
// Ports: go/tx_word start a frame; rx_word valid while fdone; sck/mosi pins.
module adc_spi_frame
    import adc_spi_seq_pkg::*;
#(
    parameter logic [15:0] CLK_DIV = 16'd2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        go,
    input  logic [15:0] tx_word,
    input  logic        miso_s,
    output logic [15:0] rx_word,
    output logic        fdone,
    output logic        sck,
    output logic        mosi
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [14:0] tx_q, tx_d;
    logic [14:0] sh_q, sh_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        last_cnt;

    assign last_cnt = (cnt_q == CLK_DIV - 16'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        tx_d    = tx_q;
        sh_d    = sh_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        fdone   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (go) begin
                    state_d = SETUP;
                    mosi_d  = tx_word[15];
                    tx_d    = tx_word[14:0];
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (last_cnt) begin
                    state_d = SCK_LO;
                    sck_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            SCK_LO: begin
                if (last_cnt) begin
                    // Next bit goes out on the rising edge so it is
                    // stable across the following falling edge.
                    state_d = SCK_HI;
                    sck_d   = 1'b1;
                    cnt_d   = '0;
                    mosi_d  = tx_q[14];
                    tx_d    = {tx_q[13:0], 1'b0};
                end
            end
            SCK_HI: begin
                if (last_cnt) begin
                    sh_d  = {sh_q[13:0], miso_s};
                    cnt_d = '0;
                    if (bit_q == 4'd15) begin
                        state_d = IDLE;
                        fdone   = 1'b1;
                    end else begin
                        state_d = SCK_LO;
                        sck_d   = 1'b0;
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            sh_q    <= '0;
            sck_q   <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            sh_q    <= sh_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

    // Last bit is appended combinationally so the word is whole during fdone.
    assign rx_word = {sh_q, miso_s};
    assign sck     = sck_q;
    assign mosi    = mosi_q;

endmodule

// File: rtl/adc_spi_seq.sv
// Four-frame pipelined AD7928 read of three phase-current channels.
// Ports: start/busy/done/err handshake, val_a..c samples, SPI pins.
module adc_spi_seq
    import adc_spi_seq_pkg::*;
#(
    parameter logic [15:0] CLK_DIV = 16'd2,
    parameter logic [15:0] CS_GAP  = 16'd4,
    parameter logic [2:0]  CH_A    = 3'd0,
    parameter logic [2:0]  CH_B    = 3'd1,
    parameter logic [2:0]  CH_C    = 3'd2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [SAMPLE_W-1:0] val_a,
    output logic [SAMPLE_W-1:0] val_b,
    output logic [SAMPLE_W-1:0] val_c,
    output logic                spi_ss,
    output logic                spi_sck,
    output logic                spi_mosi,
    input  logic                spi_miso
);

    localparam logic [1:0] LAST_F = 2'(N_FRAMES - 1);

    seq_e                seq_q, seq_d;
    logic [1:0]          f_q, f_d;
    logic [15:0]         gcnt_q, gcnt_d;
    logic                ss_q, ss_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                sticky_q, sticky_d;
    logic [1:0]          sync_q, sync_d;
    logic [SAMPLE_W-1:0] stg_a_q, stg_a_d;
    logic [SAMPLE_W-1:0] stg_b_q, stg_b_d;
    logic [SAMPLE_W-1:0] stg_c_q, stg_c_d;
    logic [SAMPLE_W-1:0] val_a_q, val_a_d;
    logic [SAMPLE_W-1:0] val_b_q, val_b_d;
    logic [SAMPLE_W-1:0] val_c_q, val_c_d;

    logic                go;
    logic [1:0]          f_go;
    logic [15:0]         tx_word;
    logic [15:0]         rx_word;
    logic                fdone;
    logic [2:0]          rx_addr;
    logic [SAMPLE_W-1:0] rx_data;
    logic                unused_lead;

    function automatic logic [2:0] addr_of(input logic [1:0] f);
        case (f)
            2'd1:    return CH_B;
            2'd2:    return CH_C;
            default: return CH_A;
        endcase
    endfunction

    assign rx_addr     = rx_word[RX_ADDR_LSB +: 3];
    assign rx_data     = rx_word[SAMPLE_W-1:0];
    assign unused_lead = rx_word[15];
    assign tx_word     = ctrl_word(addr_of(f_go));

    always_comb begin
        seq_d    = seq_q;
        f_d      = f_q;
        gcnt_d   = '0;
        ss_d     = ss_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        sticky_d = sticky_q;
        sync_d   = {sync_q[0], spi_miso};
        stg_a_d  = stg_a_q;
        stg_b_d  = stg_b_q;
        stg_c_d  = stg_c_q;
        val_a_d  = val_a_q;
        val_b_d  = val_b_q;
        val_c_d  = val_c_q;
        go       = 1'b0;
        f_go     = f_q;
        unique case (seq_q)
            SQ_IDLE: begin
                // busy stays up through the done cycle
                if (done_q) busy_d = 1'b0;
                if (start && !busy_q) begin
                    seq_d  = SQ_XFER;
                    f_d    = '0;
                    f_go   = '0;
                    go     = 1'b1;
                    ss_d   = 1'b0;
                    busy_d = 1'b1;
                end
            end
            SQ_XFER: begin
                if (fdone) begin
                    seq_d = SQ_GAP;
                    ss_d  = 1'b1;
                    // Frame f carries the result addressed in frame f-1.
                    if (f_q != 2'd0) begin
                        if (rx_addr == addr_of(f_q - 2'd1)) begin
                            case (f_q)
                                2'd1:    stg_a_d = rx_data;
                                2'd2:    stg_b_d = rx_data;
                                default: stg_c_d = rx_data;
                            endcase
                        end else begin
                            sticky_d = 1'b1;
                        end
                    end
                end
            end
            SQ_GAP: begin
                gcnt_d = gcnt_q + 16'd1;
                if (gcnt_q == CS_GAP - 16'd1) begin
                    gcnt_d = '0;
                    if (f_q != LAST_F) begin
                        seq_d = SQ_XFER;
                        f_d   = f_q + 2'd1;
                        f_go  = f_q + 2'd1;
                        go    = 1'b1;
                        ss_d  = 1'b0;
                    end else begin
                        seq_d    = SQ_IDLE;
                        done_d   = 1'b1;
                        err_d    = sticky_q;
                        sticky_d = 1'b0;
                        val_a_d  = stg_a_q;
                        val_b_d  = stg_b_q;
                        val_c_d  = stg_c_q;
                    end
                end
            end
            default: seq_d = SQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            seq_q    <= SQ_IDLE;
            f_q      <= '0;
            gcnt_q   <= '0;
            ss_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            sync_q   <= '0;
            stg_a_q  <= '0;
            stg_b_q  <= '0;
            stg_c_q  <= '0;
            val_a_q  <= '0;
            val_b_q  <= '0;
            val_c_q  <= '0;
        end else begin
            seq_q    <= seq_d;
            f_q      <= f_d;
            gcnt_q   <= gcnt_d;
            ss_q     <= ss_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            sync_q   <= sync_d;
            stg_a_q  <= stg_a_d;
            stg_b_q  <= stg_b_d;
            stg_c_q  <= stg_c_d;
            val_a_q  <= val_a_d;
            val_b_q  <= val_b_d;
            val_c_q  <= val_c_d;
        end
    end

    adc_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk     (clk),
        .rstn    (rstn),
        .go      (go),
        .tx_word (tx_word),
        .miso_s  (sync_q[1]),
        .rx_word (rx_word),
        .fdone   (fdone),
        .sck     (spi_sck),
        .mosi    (spi_mosi)
    );

    assign spi_ss = ss_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign val_a  = val_a_q;
    assign val_b  = val_b_q;
    assign val_c  = val_c_q;

endmodule

// File: tb/tb_adc_spi_seq.sv
// Bench for adc_spi_seq: two parameterisations sharing one AD7928 model.
// Randomised bursts checked against a channel-level reference model.
module tb_adc_spi_seq;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        spi_miso = 1'b0;
    logic        sel = 1'b0;

    logic [1:0]  st, busy, done, err, ss, sck, mosi;
    logic [11:0] va [2];
    logic [11:0] vb [2];
    logic [11:0] vc [2];

    always #5 clk = ~clk;

    assign st[0] = start & (sel == 1'b0);
    assign st[1] = start & (sel == 1'b1);

    adc_spi_seq u_dut0 (
        .clk(clk), .rstn(rstn), .start(st[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]),
        .val_a(va[0]), .val_b(vb[0]), .val_c(vc[0]),
        .spi_ss(ss[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
        .spi_miso(spi_miso)
    );

    adc_spi_seq #(
        .CLK_DIV(16'd3), .CS_GAP(16'd1),
        .CH_A(3'd7), .CH_B(3'd4), .CH_C(3'd6)
    ) u_dut1 (
        .clk(clk), .rstn(rstn), .start(st[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]),
        .val_a(va[1]), .val_b(vb[1]), .val_c(vc[1]),
        .spi_ss(ss[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
        .spi_miso(spi_miso)
    );

    logic        m_ss, m_sck, m_mosi, m_busy, m_done, m_err;
    logic [11:0] m_va, m_vb, m_vc;
    assign m_ss   = ss[sel];
    assign m_sck  = sck[sel];
    assign m_mosi = mosi[sel];
    assign m_busy = busy[sel];
    assign m_done = done[sel];
    assign m_err  = err[sel];
    assign m_va   = va[sel];
    assign m_vb   = vb[sel];
    assign m_vc   = vc[sel];

    // ADC model: result of the address written in frame n comes back in
    // frame n+1 as {0, addr, data}; bits change on SCK falling edges.
    logic [11:0] mem [8];
    int          bad_frame = 0;
    int          fno = 0;
    int          k = 0;
    logic [15:0] sh_in = '0;
    logic [15:0] resp = '0;
    logic [15:0] mosi_w [4];
    logic [2:0]  m_addr;

    always @(posedge m_busy) fno = 0;

    always @(negedge m_ss) begin
        k = 0;
        sh_in = '0;
    end

    always @(negedge m_sck) begin
        if (!m_ss && k < 16) begin
            sh_in = {sh_in[14:0], m_mosi};
            spi_miso = resp[15-k];
            k++;
        end
    end

    always @(posedge m_ss) begin
        if (fno < 4) mosi_w[fno] = sh_in;
        m_addr = sh_in[12:10];
        resp = {1'b0, (fno + 1 == bad_frame) ? 3'd5 : m_addr, mem[m_addr]};
        fno++;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    logic [11:0] ref_stg [2][3];

    task automatic clear_ref();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                ref_stg[i][j] = '0;
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 8; i++) begin
            if (mode == 1) mem[i] = 12'hFFF;
            else if (mode == 2) mem[i] = 12'h000;
            else mem[i] = 12'($urandom);
        end
    endtask

    task automatic burst(input int inst, input bit pulses);
        int          n, cd, cg, ss_low, falls, last_fall, min_per, extra;
        bit          exp_err;
        logic        prev_sck;
        logic [2:0]  ch [3];
        logic [15:0] exp_w;
        if (inst == 0) begin
            cd = 2; cg = 4;
            ch[0] = 3'd0; ch[1] = 3'd1; ch[2] = 3'd2;
        end else begin
            cd = 3; cg = 1;
            ch[0] = 3'd7; ch[1] = 3'd4; ch[2] = 3'd6;
        end
        for (int j = 0; j < 3; j++)
            if (bad_frame != j + 1) ref_stg[inst][j] = mem[ch[j]];
        exp_err = (bad_frame >= 1 && bad_frame <= 3);

        sel = inst[0];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk("busy_rise", 32'(m_busy), 32'd1);
        ss_low = 0; falls = 0; last_fall = 0; min_per = 1000000;
        prev_sck = m_sck;
        while (!m_done && n < 3000) begin
            if (!m_ss) ss_low++;
            if (prev_sck && !m_sck && !m_ss) begin
                if (falls > 0 && n - last_fall < min_per)
                    min_per = n - last_fall;
                falls++;
                last_fall = n;
            end
            prev_sck = m_sck;
            @(negedge clk);
            n++;
            start = pulses && (n == 10);
        end
        chk("burst_len", 32'(n), 32'(1 + 4 * (33 * cd + cg)));
        chk("busy_at_done", 32'(m_busy), 32'd1);
        chk("val_a", 32'(m_va), 32'(ref_stg[inst][0]));
        chk("val_b", 32'(m_vb), 32'(ref_stg[inst][1]));
        chk("val_c", 32'(m_vc), 32'(ref_stg[inst][2]));
        chk("err", 32'(m_err), 32'(exp_err));
        start = pulses;
        @(negedge clk);
        start = 1'b0;
        chk("done_width", 32'(m_done), 32'd0);
        chk("busy_fall", 32'(m_busy), 32'd0);
        chk("ss_low_cycles", 32'(ss_low), 32'(4 * 33 * cd));
        chk("sck_falls", 32'(falls), 32'd64);
        chk("sck_period", 32'(min_per), 32'(2 * cd));
        for (int f = 0; f < 4; f++) begin
            exp_w = 16'h8330 | (16'(ch[f % 3]) << 10);
            chk("mosi_word", 32'(mosi_w[f]), 32'(exp_w));
        end
        if (pulses) begin
            extra = 0;
            repeat (400) begin
                @(negedge clk);
                if (m_done || m_busy) extra++;
            end
            chk("ignored_start", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int n;
        clear_ref();
        fill_mem(2);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ss", 32'(ss[i]), 32'd1);
            chk("rst_sck", 32'(sck[i]), 32'd1);
            chk("rst_mosi", 32'(mosi[i]), 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_done", 32'(done[i]), 32'd0);
            chk("rst_err", 32'(err[i]), 32'd0);
            chk("rst_vals", {8'd0, va[i] | vb[i] | vc[i]}, 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);

        fill_mem(0);
        mem[0] = 12'h123; mem[1] = 12'h456; mem[2] = 12'h789;
        burst(0, 1'b0);

        // reset during SCK_LO of frame 1
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 73) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_sck", 32'(m_sck), 32'd0);
        chk("pre_rst_ss", 32'(m_ss), 32'd0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ss", 32'(m_ss), 32'd1);
        chk("mid_rst_sck", 32'(m_sck), 32'd1);
        chk("mid_rst_busy", 32'(m_busy), 32'd0);
        chk("mid_rst_vals", {8'd0, m_va | m_vb | m_vc}, 32'd0);
        clear_ref();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        fill_mem(0);
        burst(0, 1'b0);

        fill_mem(0);
        bad_frame = 2;
        burst(0, 1'b0);
        bad_frame = 0;

        fill_mem(0);
        burst(0, 1'b1);

        fill_mem(1);
        burst(0, 1'b0);
        fill_mem(2);
        burst(0, 1'b0);

        fill_mem(0);
        burst(1, 1'b0);
        fill_mem(1);
        burst(1, 1'b0);
        fill_mem(2);
        burst(1, 1'b0);

        repeat (6) begin
            fill_mem(0);
            bad_frame = int'($urandom_range(0, 3));
            burst(int'($urandom_range(0, 1)), 1'b0);
        end
        bad_frame = 0;
        fill_mem(0);
        burst(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_spi_seq.md
# adc_spi_seq

Sampling-sequencer stage that consumes the one-cycle ADC trigger pulse from the PWM-hold detector and reads three phase-current channels from an AD7928-class 12-bit, 8-channel SPI ADC. It runs a four-frame pipelined SPI burst because each result arrives one frame after its channel address was sent. It then presents three registered 12-bit samples with a one-cycle `done` pulse to the downstream current-transform logic.

## Interface
- `CLK_DIV`, 16'd2: SCK half-period in `clk` cycles; legal range 1..65535.
- `CS_GAP`, 16'd4: `spi_ss` high time between frames in `clk` cycles; legal range 1..65535.
- `CH_A`, 3'd0: ADC channel for `val_a`.
- `CH_B`, 3'd1: ADC channel for `val_b`.
- `CH_C`, 3'd2: ADC channel for `val_c`.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle trigger pulse from the hold detector.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when new samples are valid.
- `err`  out  1  registered with `done`; high if any returned address mismatched.
- `val_a`, `val_b`, `val_c`  out  12 each  latest samples, unsigned straight binary.
- `spi_ss`  out  1  ADC chip select, active-low.
- `spi_sck`  out  1  serial clock, idle high.
- `spi_mosi`  out  1  control word, MSB first.
- `spi_miso`  in  1  ADC data; synchronised by the same two-flop chain used for every asynchronous input.

## Operation
- States: IDLE, SETUP, SCK_LO, SCK_HI, GAP.
- In IDLE, `start`=1 sets frame index f=0, drives `spi_ss` low and enters SETUP. `start` is ignored whenever `busy`=1.
- Control word for address ADD: {1,0,0,ADD[2:0],2'b11,0,0,1,1,4'b0000}. This means WRITE, no sequencer, normal power, range 0..REFIN, straight binary.
- Addresses per frame: f=0 CH_A, f=1 CH_B, f=2 CH_C, f=3 CH_A (dummy).
- Each frame carries 16 bits. For every bit, SCK_LO lasts CLK_DIV cycles, then SCK_HI lasts CLK_DIV cycles.
- The MOSI bit is updated on entry to SETUP and on entry to each SCK_HI for the next bit. It is therefore stable across the following SCK falling edge.
- The synchronised MISO is sampled on the last cycle of each SCK_HI into a 16-bit shift register, MSB first.
- After bit 15, `spi_ss` goes high and the block enters GAP for CS_GAP cycles. The next frame follows if f<3; otherwise it returns to IDLE.
- Frame f≥1 returns the result for address f-1. Received bits [14:12] must equal the expected address; bits [11:0] are the data.
- On a match, the data goes to a staging register. On a mismatch, the staging register keeps its old value and a sticky mismatch flag is set.
- At the end of GAP after frame 3: `val_*` load from staging, `err` takes the sticky flag, `done`=1 for one cycle, `busy` drops, and the sticky flag clears.
- Reset values: `spi_ss`=1, `spi_sck`=1, `spi_mosi`=0, `busy`=0, `done`=0, `err`=0, `val_*`=0, state IDLE. An asserted `rstn` aborts any burst immediately with these values.

## Timing
- SETUP length is CLK_DIV cycles with SCK high and SS low.
- Frame SS-low length is (1+32)·CLK_DIV cycles.
- Burst length, `start` to `done`, is 1 + 4·(33·CLK_DIV + CS_GAP) cycles. With the defaults this is 1 + 4·70 = 281 cycles.
- MISO capture lags the pin by 2 cycles. CLK_DIV≥2 guarantees the sampled bit is the one the ADC shifted on the preceding falling edge. CLK_DIV=1 is legal only for loopback test.
- `start` in the same cycle as `done` is ignored, because `busy` is still high in that cycle.

## Structure
- Shared package holds:
  - the state enum;
  - control-word field constants (WRITE, PM, RANGE, CODING bit positions);
  - the frame count (4);
  - the 12-bit sample width.
- Sub-module `adc_spi_frame` shifts one 16-bit frame: inputs `go` and `tx_word`; outputs `rx_word` and `fdone`; drives SCK and MOSI. The top level holds the frame sequencer, address checking and output registers.

## Test plan
- Reset mid-frame (assert `rstn` during SCK_LO of frame 1) -> `spi_ss`=1, `spi_sck`=1, `val_*`=0, `busy`=0 in the same cycle; the next `start` gives a clean burst.
- Defaults with an ADC model returning CH0=0x123, CH1=0x456, CH2=0x789 -> after 281 cycles, `done`=1 for 1 cycle, `val_a`=0x123, `val_b`=0x456, `val_c`=0x789, `err`=0; MOSI words are 0x8330, 0x8730, 0x8B30, 0x8330.
- Model returns address 3'd5 in frame 2 -> `err`=1, `val_b` keeps its previous value, `val_a` and `val_c` update.
- `start` pulses at cycles +10 and +281 after the first `start` -> both are ignored; exactly one `done`.
- CH_A=7, CH_B=4, CH_C=6, CLK_DIV=3, CS_GAP=1 -> SCK period is 6 cycles; burst is 1+4·100=401 cycles; values map to the correct channels.
- Full-scale data 0xFFF and 0x000 -> reproduced exactly, with no bit slip at bit 0 or bit 15.
